// File: rtl/grid_redraw_scheduler.sv
// -----------------------------------------------------------------------------
// grid_redraw_scheduler
//
// Purpose:
//   Sequences rectangle-fill commands for a 3x3 game-board display towards a
//   downstream rect-fill engine (the engine owns the pixel port). Per-cell
//   dirty bits make sure only changed cells are redrawn; after reset or on a
//   redraw_all pulse the background and all nine cells are redrawn.
//
// Optional feature:
//   GRID_LINES_EN - when defined, four LINE_COLOR grid-line commands follow the
//                   background command. When undefined the gaps keep BG_COLOR
//                   and a full redraw is exactly 10 commands.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_cell_color   9 x 3-bit colours, cell i = row*3+col at [3i+2:3i]
//   i_redraw_all   pulse: schedule background plus all 9 cells
//   o_cmd_valid    command valid (valid/ready handshake)
//   i_cmd_ready    engine accepts command
//   o_cmd_x0/y0    rectangle top-left corner
//   o_cmd_w/h      rectangle size
//   o_cmd_color    fill colour
//   o_busy         FSM active or any work pending
//   o_frame_done   1-cycle pulse once all pending work has been accepted
// -----------------------------------------------------------------------------
module grid_redraw_scheduler #(
  parameter int         CELL_W     = 104,
  parameter int         CELL_H     = 77,
  parameter int         GAP        = 5,
  parameter int         SCREEN_W   = 320,
  parameter int         SCREEN_H   = 240,
  parameter logic [2:0] BG_COLOR   = 3'b000,
  parameter logic [2:0] LINE_COLOR = 3'b111
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [26:0] i_cell_color,
  input  logic        i_redraw_all,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [8:0]  o_cmd_x0,
  output logic [7:0]  o_cmd_y0,
  output logic [8:0]  o_cmd_w,
  output logic [7:0]  o_cmd_h,
  output logic [2:0]  o_cmd_color,
  output logic        o_busy,
  output logic        o_frame_done
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BG_ISSUE   = 2'd1,
`ifdef GRID_LINES_EN
    LINE_ISSUE = 2'd3,
`endif
    CELL_ISSUE = 2'd2
  } state_t;

  // Coordinates are computed 10 bits wide and truncated at the output regs.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
  } rect_t;

  localparam logic [9:0] STEP_X  = 10'(CELL_W + GAP);
  localparam logic [9:0] STEP_Y  = 10'(CELL_H + GAP);
  localparam rect_t      BG_RECT = {10'd0, 10'd0, 10'(SCREEN_W), 10'(SCREEN_H)};

  // Lowest set bit index of the dirty vector (0 when empty; caller checks).
  function automatic logic [3:0] lowest_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Screen rectangle of cell k (k = row*3 + col).
  function automatic rect_t cell_rect(input logic [3:0] k);
    rect_t      r;
    logic [3:0] col;
    logic [3:0] row;
    col = k % 4'd3;
    row = k / 4'd3;
    r.x = 10'(col) * STEP_X;
    r.y = 10'(row) * STEP_Y;
    r.w = 10'(CELL_W);
    r.h = 10'(CELL_H);
    return r;
  endfunction

`ifdef GRID_LINES_EN
  // Grid lines: two vertical, then two horizontal.
  function automatic rect_t line_rect(input logic [1:0] idx);
    rect_t r;
    case (idx)
      2'd0:    r = {10'(CELL_W), 10'd0, 10'(GAP), 10'(SCREEN_H)};
      2'd1:    r = {10'(2 * CELL_W + GAP), 10'd0, 10'(GAP), 10'(SCREEN_H)};
      2'd2:    r = {10'd0, 10'(CELL_H), 10'(SCREEN_W), 10'(GAP)};
      default: r = {10'd0, 10'(2 * CELL_H + GAP), 10'(SCREEN_W), 10'(GAP)};
    endcase
    return r;
  endfunction
`endif

  // Registers
  state_t      r_state;
  logic [8:0]  r_dirty;
  logic        r_bg_pend;
  logic [26:0] r_snapshot;
  logic [3:0]  r_k;
  logic        r_cmd_valid;
  logic [8:0]  r_cmd_x0;
  logic [7:0]  r_cmd_y0;
  logic [8:0]  r_cmd_w;
  logic [7:0]  r_cmd_h;
  logic [2:0]  r_cmd_color;
  logic        r_busy;
  logic        r_frame_done;
`ifdef GRID_LINES_EN
  logic [1:0]  r_line_idx;
  logic [1:0]  w_line_sel;
`endif

  // Wires
  logic [8:0]  w_chg;
  logic        w_xfer;
  logic [8:0]  w_clr;
  logic [3:0]  w_pick;
  logic [26:0] w_pick_sh;
  logic [2:0]  w_pick_color;
  rect_t       w_cell_rect;
  rect_t       w_ld_rect;
  logic [2:0]  w_ld_color;
  logic [8:0]  w_dirty_nxt;
  logic        w_bg_nxt;
  logic        w_last_xfer;
  logic        w_done_nxt;
  logic        w_busy_nxt;

  assign w_xfer       = r_cmd_valid & i_cmd_ready;
  assign w_pick       = lowest_idx(r_dirty);
  assign w_pick_sh    = i_cell_color >> (5'(w_pick) * 5'd3);
  assign w_pick_color = 3'(w_pick_sh);
  assign w_cell_rect  = cell_rect(w_pick);
  assign w_clr        = (w_xfer && (r_state == CELL_ISSUE)) ? (9'd1 << r_k) : 9'd0;

  // A change landing on the accept edge of the same cell keeps it dirty
  // (set wins), and redraw_all overrides everything including clears.
  assign w_dirty_nxt  = i_redraw_all ? 9'h1FF : ((r_dirty & ~w_clr) | w_chg);
  assign w_bg_nxt     = i_redraw_all ? 1'b1
                      : (r_bg_pend & ~(w_xfer && (r_state == BG_ISSUE)));

`ifdef GRID_LINES_EN
  assign w_line_sel   = (r_state == BG_ISSUE) ? 2'd0 : (r_line_idx + 2'd1);
  assign w_last_xfer  = w_xfer & ((r_state == CELL_ISSUE) |
                                  ((r_state == LINE_ISSUE) & (r_line_idx == 2'd3)));
`else
  assign w_last_xfer  = w_xfer;
`endif

  // frame_done / busy are registered from next-cycle values.
  assign w_done_nxt   = w_last_xfer & (w_dirty_nxt == 9'd0) & ~w_bg_nxt;
  assign w_busy_nxt   = ((r_state != IDLE) & ~w_last_xfer) | (|w_dirty_nxt) | w_bg_nxt;

  // Per-cell change detect against the last sampled colours.
  always_comb begin
    w_chg = 9'd0;
    for (int i = 0; i < 9; i++) begin
      w_chg[i] = |(i_cell_color[3*i +: 3] ^ r_snapshot[3*i +: 3]);
    end
  end

  // Payload of the next command to load, chosen by the current state.
  always_comb begin
    w_ld_rect  = w_cell_rect;
    w_ld_color = w_pick_color;
    case (r_state)
      IDLE: begin
        if (r_bg_pend) begin
          w_ld_rect  = BG_RECT;
          w_ld_color = BG_COLOR;
        end else begin
          w_ld_rect  = w_cell_rect;
          w_ld_color = w_pick_color;
        end
      end
`ifdef GRID_LINES_EN
      BG_ISSUE, LINE_ISSUE: begin
        w_ld_rect  = line_rect(w_line_sel);
        w_ld_color = LINE_COLOR;
      end
`endif
      default: begin
        w_ld_rect  = w_cell_rect;
        w_ld_color = w_pick_color;
      end
    endcase
  end

  // Scheduler FSM, dirty tracking and registered command outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_dirty      <= 9'h1FF;
      r_bg_pend    <= 1'b1;
      r_snapshot   <= i_cell_color;
      r_k          <= 4'd0;
      r_cmd_valid  <= 1'b0;
      r_cmd_x0     <= 9'd0;
      r_cmd_y0     <= 8'd0;
      r_cmd_w      <= 9'd0;
      r_cmd_h      <= 8'd0;
      r_cmd_color  <= 3'd0;
      r_busy       <= 1'b1;
      r_frame_done <= 1'b0;
`ifdef GRID_LINES_EN
      r_line_idx   <= 2'd0;
`endif
    end else begin
      r_snapshot   <= i_cell_color;
      r_dirty      <= w_dirty_nxt;
      r_bg_pend    <= w_bg_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
      case (r_state)
        IDLE: begin
          if (r_bg_pend || (|r_dirty)) begin
            r_state     <= r_bg_pend ? BG_ISSUE : CELL_ISSUE;
            r_k         <= w_pick;
            r_cmd_valid <= 1'b1;
            r_cmd_x0    <= 9'(w_ld_rect.x);
            r_cmd_y0    <= 8'(w_ld_rect.y);
            r_cmd_w     <= 9'(w_ld_rect.w);
            r_cmd_h     <= 8'(w_ld_rect.h);
            r_cmd_color <= w_ld_color;
          end else begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
          end
        end
        BG_ISSUE: begin
          if (w_xfer) begin
`ifdef GRID_LINES_EN
            // Go straight into the first grid line; valid stays high.
            r_state     <= LINE_ISSUE;
            r_line_idx  <= w_line_sel;
            r_cmd_x0    <= 9'(w_ld_rect.x);
            r_cmd_y0    <= 8'(w_ld_rect.y);
            r_cmd_w     <= 9'(w_ld_rect.w);
            r_cmd_h     <= 8'(w_ld_rect.h);
            r_cmd_color <= w_ld_color;
`else
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
`endif
          end else begin
            r_state     <= BG_ISSUE;
          end
        end
`ifdef GRID_LINES_EN
        LINE_ISSUE: begin
          if (w_xfer && (r_line_idx == 2'd3)) begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
          end else if (w_xfer) begin
            r_line_idx  <= w_line_sel;
            r_cmd_x0    <= 9'(w_ld_rect.x);
            r_cmd_y0    <= 8'(w_ld_rect.y);
            r_cmd_w     <= 9'(w_ld_rect.w);
            r_cmd_h     <= 8'(w_ld_rect.h);
            r_cmd_color <= w_ld_color;
          end else begin
            r_state     <= LINE_ISSUE;
          end
        end
`endif
        CELL_ISSUE: begin
          if (w_xfer) begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
          end else begin
            r_state     <= CELL_ISSUE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_x0     = r_cmd_x0;
  assign o_cmd_y0     = r_cmd_y0;
  assign o_cmd_w      = r_cmd_w;
  assign o_cmd_h      = r_cmd_h;
  assign o_cmd_color  = r_cmd_color;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_grid_redraw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_grid_redraw_scheduler
//
// Directed, table-driven bench. Accepted commands are logged by a monitor with
// the edge number they were accepted on; expected command sequences are kept
// in hand-filled tables. Define GRID_LINES_EN to check the grid-line build.
// -----------------------------------------------------------------------------
module tb_grid_redraw_scheduler;

`ifdef GRID_LINES_EN
  localparam int NL = 4;
`else
  localparam int NL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] cell_color;
  logic        redraw_all;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [8:0]  w;
  logic [7:0]  h;
  logic [2:0]  col;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  grid_redraw_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cell_color (cell_color),
    .i_redraw_all (redraw_all),
    .o_cmd_valid  (cmd_valid),
    .i_cmd_ready  (cmd_ready),
    .o_cmd_x0     (x0),
    .o_cmd_y0     (y0),
    .o_cmd_w      (w),
    .o_cmd_h      (h),
    .o_cmd_color  (col),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  typedef struct { int x; int y; int w; int h; int c; int cyc; } cmd_t;
  typedef struct { logic [2:0] cin; int x; int y; int w; int h; int c; } vec_t;

  cmd_t log_q[$];
  vec_t vz[10];   // full redraw, all cells colour 0
  vec_t vp[10];   // full redraw, patterned colours (cin drives the cell)
  vec_t vl[4];    // grid lines
  int   cyc    = 0;
  int   n_done = 0;
  int   checks = 0;
  int   errors = 0;

  // Log every accepted command with the number of the edge that accepted it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmd_valid && cmd_ready)
      log_q.push_back('{int'(x0), int'(y0), int'(w), int'(h), int'(col), cyc + 1});
    if (!rst && frame_done) n_done <= n_done + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cmd(input string name, input int idx, input vec_t e);
    checks++;
    if (idx >= log_q.size()) begin
      errors++;
      $display("FAIL %s: no command at index %0d, expected (%0d,%0d,%0d,%0d,c%0d)",
               name, idx, e.x, e.y, e.w, e.h, e.c);
    end else if (log_q[idx].x != e.x || log_q[idx].y != e.y || log_q[idx].w != e.w ||
                 log_q[idx].h != e.h || log_q[idx].c != e.c) begin
      errors++;
      $display("FAIL %s: got (%0d,%0d,%0d,%0d,c%0d), expected (%0d,%0d,%0d,%0d,c%0d)",
               name, log_q[idx].x, log_q[idx].y, log_q[idx].w, log_q[idx].h, log_q[idx].c,
               e.x, e.y, e.w, e.h, e.c);
    end
  endtask

  function automatic vec_t sel(input bit pat, input int i);
    if (pat) return vp[i];
    else     return vz[i];
  endfunction

  // Background, optional lines, then cells 0..8 starting at log index base.
  task automatic check_full(input string tag, input bit pat, input int base);
    chk_cmd({tag, "_bg"}, base, sel(pat, 0));
`ifdef GRID_LINES_EN
    for (int i = 0; i < 4; i++)
      chk_cmd($sformatf("%s_line%0d", tag, i), base + 1 + i, vl[i]);
`endif
    for (int i = 1; i < 10; i++)
      chk_cmd($sformatf("%s_cell%0d", tag, i - 1), base + NL + i, sel(pat, i));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy || cmd_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_reached"}, int'(n < 400), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, int'(cmd_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    int          d0;
    int          m;
    int          lat;
    int          n;
    logic [36:0] exp37;
    logic [26:0] pat_color;

    // Expected tables: x = col*109, y = row*82, cells 104x77.
    vz[0] = '{3'd0,   0,   0, 320, 240, 0};
    vz[1] = '{3'd0,   0,   0, 104,  77, 0};
    vz[2] = '{3'd0, 109,   0, 104,  77, 0};
    vz[3] = '{3'd0, 218,   0, 104,  77, 0};
    vz[4] = '{3'd0,   0,  82, 104,  77, 0};
    vz[5] = '{3'd0, 109,  82, 104,  77, 0};
    vz[6] = '{3'd0, 218,  82, 104,  77, 0};
    vz[7] = '{3'd0,   0, 164, 104,  77, 0};
    vz[8] = '{3'd0, 109, 164, 104,  77, 0};
    vz[9] = '{3'd0, 218, 164, 104,  77, 0};
    vp[0] = '{3'd0,   0,   0, 320, 240, 0};
    vp[1] = '{3'd1,   0,   0, 104,  77, 1};
    vp[2] = '{3'd2, 109,   0, 104,  77, 2};
    vp[3] = '{3'd3, 218,   0, 104,  77, 3};
    vp[4] = '{3'd4,   0,  82, 104,  77, 4};
    vp[5] = '{3'd5, 109,  82, 104,  77, 5};
    vp[6] = '{3'd6, 218,  82, 104,  77, 6};
    vp[7] = '{3'd7,   0, 164, 104,  77, 7};
    vp[8] = '{3'd0, 109, 164, 104,  77, 0};
    vp[9] = '{3'd1, 218, 164, 104,  77, 1};
    vl[0] = '{3'd0, 104,   0,   5, 240, 7};
    vl[1] = '{3'd0, 213,   0,   5, 240, 7};
    vl[2] = '{3'd0,   0,  77, 320,   5, 7};
    vl[3] = '{3'd0,   0, 159, 320,   5, 7};
    pat_color = 27'd0;
    for (int i = 0; i < 9; i++) pat_color[3*i +: 3] = vp[i + 1].cin;

    // Reset state
    rst = 1'b1; cell_color = 27'd0; redraw_all = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_payload_zero", int'(|{x0, y0, w, h, col}), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 1);

    // T1: full redraw after reset
    b = log_q.size(); d0 = n_done;
    rst = 1'b0;
    wait_idle("t1");
    chk("t1_count", log_q.size() - b, 10 + NL);
    check_full("t1", 1'b0, b);
    chk("t1_frame_done", n_done - d0, 1);
    chk("t1_busy", int'(busy), 0);

    // T2: single cell change, latency N+2
    b = log_q.size(); d0 = n_done; m = cyc;
    cell_color[8:6] = 3'b100;
    wait_idle("t2");
    chk("t2_count", log_q.size() - b, 1);
    chk_cmd("t2_cmd", b, '{3'd4, 218, 0, 104, 77, 4});
    lat = (log_q.size() > b) ? log_q[b].cyc : -1;
    chk("t2_accept_edge", lat, m + 3);
    chk("t2_frame_done", n_done - d0, 1);

    // T3: 20-cycle stall on cell 5
    b = log_q.size(); d0 = n_done;
    cmd_ready = 1'b0;
    cell_color[17:15] = 3'b011;
    wait_valid("t3");
    exp37 = {9'd218, 8'd82, 9'd104, 8'd77, 3'd3};
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t3_hold%0d", i), int'(cmd_valid && ({x0, y0, w, h, col} == exp37)), 1);
      @(negedge clk);
    end
    chk("t3_no_xfer_while_stalled", log_q.size() - b, 0);
    cmd_ready = 1'b1;
    wait_idle("t3");
    chk("t3_count", log_q.size() - b, 1);
    chk_cmd("t3_cmd", b, '{3'd3, 218, 82, 104, 77, 3});
    chk("t3_frame_done", n_done - d0, 1);

    // T4: cell 3 changes on its own accept edge
    b = log_q.size(); d0 = n_done;
    cmd_ready = 1'b0;
    cell_color[11:9] = 3'b001;
    wait_valid("t4");
    chk("t4_inflight_color", int'(col), 1);
    cmd_ready = 1'b1;
    cell_color[11:9] = 3'b010;
    wait_idle("t4");
    chk("t4_count", log_q.size() - b, 2);
    chk_cmd("t4_first", b, '{3'd1, 0, 82, 104, 77, 1});
    chk_cmd("t4_reissue", b + 1, '{3'd2, 0, 82, 104, 77, 2});
    chk("t4_frame_done", n_done - d0, 1);

    // T5: redraw_all with patterned colours
    b = log_q.size(); d0 = n_done;
    cell_color = pat_color;
    redraw_all = 1'b1;
    @(negedge clk);
    redraw_all = 1'b0;
    wait_idle("t5");
    chk("t5_count", log_q.size() - b, 10 + NL);
    check_full("t5", 1'b1, b);
    chk("t5_frame_done", n_done - d0, 1);

    // T6: reset in the middle of a redraw while a command is valid
    b = log_q.size();
    redraw_all = 1'b1;
    @(negedge clk);
    redraw_all = 1'b0;
    n = 0;
    while (!((log_q.size() - b >= 4) && cmd_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_midway_reached", int'(n < 200), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", int'(cmd_valid), 0);
    chk("t6_rst_payload_zero", int'(|{x0, y0, w, h, col}), 0);
    rst = 1'b0;
    b = log_q.size(); d0 = n_done;
    wait_idle("t6");
    chk("t6_count", log_q.size() - b, 10 + NL);
    check_full("t6", 1'b1, b);
    chk("t6_frame_done", n_done - d0, 1);

    // T7: redraw_all on the background accept edge
    b = log_q.size(); d0 = n_done;
    cmd_ready = 1'b0;
    redraw_all = 1'b1;
    @(negedge clk);
    redraw_all = 1'b0;
    wait_valid("t7");
    chk("t7_bg_width", int'(w), 320);
    cmd_ready = 1'b1;
    redraw_all = 1'b1;
    @(negedge clk);
    redraw_all = 1'b0;
    wait_idle("t7");
    chk("t7_count", log_q.size() - b, 11 + 2 * NL);
    chk_cmd("t7_bg_first", b, vp[0]);
    check_full("t7", 1'b1, b + 1 + NL);
    chk("t7_frame_done", n_done - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
